gpu_frame_sequencer: RTL and testbench
======================================

// Module: gpu_frame_sequencer
// PURPOSE
//  Frame-level controller in front of GPU_top. Streams a host vertex buffer into
//  the GPU vertex memory, waits a settle interval, pulses start, then waits for
//  frame_end and reports completion.
//  Replaces the hand-sequenced load/start/wait flow with one handshake-driven FSM.
// PARAMETERS
//  M                  11     integer bits of a vertex word
//  N                  7      fraction bits of a vertex word
//  VERTEX_MEM_DEPTH   16384  GPU vertex memory depth in words; AW = $clog2(VERTEX_MEM_DEPTH)
//  SETTLE_CYCLES      16     idle cycles between the last memory write and gpu_start (>=1)
//  TIMEOUT_CYCLES     2**24  watchdog limit in RUN (used only with FRAME_TIMEOUT_EN)
// PORTS
//  clk             in   1      system clock
//  reset           in   1      asynchronous, active-high reset
//  frame_req       in   1      request one frame; sampled only in IDLE
//  frame_reload    in   1      with frame_req: 1 = load a new buffer, 0 = reuse the stored one
//  host_valid      in   1      host vertex word valid
//  host_ready      out  1      sequencer accepts a host word
//  host_data       in   M+N    signed vertex word
//  host_last       in   1      marks the final word of the buffer
//  mem_wr_en       out  1      GPU vertex memory write strobe
//  mem_wr_addr     out  AW     GPU vertex memory write address
//  mem_wr_data     out  M+N    GPU vertex memory write data
//  vertex_count    out  32     number of words loaded; drives GPU_top.vertex_count
//  gpu_start       out  1      one-cycle start pulse to GPU_top
//  gpu_frame_end   in   1      GPU_top frame_end, level
//  busy            out  1      high whenever state != IDLE
//  frame_done      out  1      one-cycle pulse when a frame finishes
//  err_overflow    out  1      sticky: buffer exceeded VERTEX_MEM_DEPTH
//  err_timeout     out  1      sticky watchdog expiry (tied 0 without the macro)
// BEHAVIOUR
//  - Reset (any time, including mid-frame): state=IDLE; every output=0; vertex_count=0; errors cleared.
//  - States: IDLE -> LOAD -> SETTLE -> START -> RUN -> DONE -> IDLE.
//  - IDLE: frame_req=1 clears both error flags.
//      - reload=1: go to LOAD with write pointer=0.
//      - reload=0 and vertex_count>0: go to SETTLE.
//      - reload=0 and vertex_count=0: go to DONE.
//    frame_req in any other state is ignored.
//  - LOAD: host_ready=1. A beat is accepted when valid&ready.
//      - The accepted beat is registered into mem_wr_en/addr/data one cycle later; addresses run 0,1,2,...
//      - vertex_count is updated with the write and equals the number of stored words.
//      - On the beat with host_last=1, go to SETTLE.
//  - Overflow: a beat accepted when the pointer == VERTEX_MEM_DEPTH is not written.
//      - err_overflow is set; host_ready stays 1 to drain until host_last.
//      - vertex_count saturates at VERTEX_MEM_DEPTH.
//  - host_valid gaps are legal; no write is issued in a gap cycle.
//  - SETTLE: counts SETTLE_CYCLES cycles, counted from the cycle after the last mem write, then goes to START.
//  - START: gpu_start=1 for exactly one cycle, then RUN.
//  - RUN: waits for a rising edge of gpu_frame_end, using a registered previous value.
//      - The previous-value register is seeded in START, so a level that is already high is not taken as an edge.
//  - DONE: frame_done=1 for one cycle, then IDLE. busy drops in that same IDLE cycle.
//  - frame_req arriving in the same cycle frame_done is high is ignored. The earliest new request is accepted in IDLE.
// CONFIGURATION
//  FRAME_TIMEOUT_EN defined:
//    - A RUN cycle counter starts at START.
//    - When it reaches TIMEOUT_CYCLES without a frame_end edge: set err_timeout, go to DONE, pulse frame_done.
//  FRAME_TIMEOUT_EN undefined: no counter; err_timeout is tied 0; RUN waits forever.
// TESTING
//  1. Reload frame, 9 words, last on word 9 -> writes at addr 0..8 with matching data; vertex_count=9;
//     gpu_start 16 cycles after the last write; frame_end edge -> frame_done one cycle after DONE entry.
//  2. Second frame_req with reload=0 -> no mem writes; SETTLE, START, RUN; vertex_count stays 9.
//  3. VERTEX_MEM_DEPTH=16, 20-word buffer -> 16 writes (addr 0..15); err_overflow=1; vertex_count=16;
//     all 20 beats accepted.
//  4. host_valid toggling 1,0,0,1 per word -> writes only after handshakes; addresses contiguous.
//  5. FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100, gpu_frame_end held 0 -> err_timeout=1 and frame_done
//     100 cycles after gpu_start.
//  6. reset asserted mid-LOAD after 5 words -> busy, mem_wr_en, vertex_count all 0 immediately;
//     next frame_req with reload=0 -> frame_done with no gpu_start.

Source files
------------

// File: rtl/gpu_frame_sequencer.sv
// gpu_frame_sequencer: frame-level controller in front of GPU_top.
// Streams a host vertex buffer into GPU vertex memory, waits a settle interval,
// pulses gpu_start, waits for a gpu_frame_end rising edge and reports frame_done.
// Optional feature macro: FRAME_TIMEOUT_EN enables the RUN-state watchdog (err_timeout).
module gpu_frame_sequencer #(
  parameter int unsigned M                = 11,
  parameter int unsigned N                = 7,
  parameter int unsigned VERTEX_MEM_DEPTH = 16384,
  parameter int unsigned SETTLE_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 2**24,
  localparam int unsigned W               = M + N,
  localparam int unsigned AW              = $clog2(VERTEX_MEM_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_req,
  input  logic                frame_reload,
  input  logic                host_valid,
  output logic                host_ready,
  input  logic signed [W-1:0] host_data,
  input  logic                host_last,
  output logic                mem_wr_en,
  output logic [AW-1:0]       mem_wr_addr,
  output logic signed [W-1:0] mem_wr_data,
  output logic [31:0]         vertex_count,
  output logic                gpu_start,
  input  logic                gpu_frame_end,
  output logic                busy,
  output logic                frame_done,
  output logic                err_overflow,
  output logic                err_timeout
);

  // Write pointer needs one extra bit to represent "memory full".
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic                r_host_ready;
  logic                r_mem_wr_en;
  logic [AW-1:0]       r_mem_wr_addr;
  logic signed [W-1:0] r_mem_wr_data;
  logic [31:0]         r_vertex_count;
  logic                r_gpu_start;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_err_overflow;
  logic                r_fe_prev;
  logic [PW-1:0]       r_wr_ptr;
  logic [SW-1:0]       r_settle_cnt;

  logic                w_accept;
  logic                w_req;
  logic                w_fe_rise;
  logic                w_ptr_full;
  logic                w_settle_done;
  logic                w_timeout;

  assign w_accept      = host_valid & r_host_ready;
  // A request coinciding with the frame_done pulse is dropped.
  assign w_req         = frame_req & ~r_frame_done;
  assign w_fe_rise     = gpu_frame_end & ~r_fe_prev;
  assign w_ptr_full    = (r_wr_ptr == PW'(VERTEX_MEM_DEPTH));
  // SETTLE is entered in the cycle of the last write, so the idle gap is SETTLE_CYCLES.
  assign w_settle_done = (r_settle_cnt == SW'(SETTLE_CYCLES));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (frame_reload) begin
            w_next_state = S_LOAD;
          end else if (r_vertex_count != 32'd0) begin
            w_next_state = S_SETTLE;
          end else begin
            w_next_state = S_DONE;
          end
        end
      end
      S_LOAD:   if (w_accept && host_last) w_next_state = S_SETTLE;
      S_SETTLE: if (w_settle_done) w_next_state = S_START;
      S_START:  w_next_state = S_RUN;
      S_RUN:    if (w_fe_rise || w_timeout) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Registered outputs, load datapath, settle counter and frame_end history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_host_ready   <= 1'b0;
      r_mem_wr_en    <= 1'b0;
      r_mem_wr_addr  <= '0;
      r_mem_wr_data  <= '0;
      r_vertex_count <= '0;
      r_gpu_start    <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_err_overflow <= 1'b0;
      r_fe_prev      <= 1'b0;
      r_wr_ptr       <= '0;
      r_settle_cnt   <= '0;
    end else begin
      r_host_ready <= (w_next_state == S_LOAD);
      r_busy       <= (w_next_state != S_IDLE);
      r_gpu_start  <= (w_next_state == S_START);
      r_frame_done <= (r_state == S_DONE);
      // Sampled every cycle, so the value seen during START seeds the RUN edge detector.
      r_fe_prev    <= gpu_frame_end;
      r_mem_wr_en  <= 1'b0;

      if (r_state == S_IDLE && w_req) begin
        r_err_overflow <= 1'b0;
        if (frame_reload) begin
          r_wr_ptr       <= '0;
          r_vertex_count <= '0;
        end
      end

      if (w_accept) begin
        if (w_ptr_full) begin
          r_err_overflow <= 1'b1;
        end else begin
          r_mem_wr_en    <= 1'b1;
          r_mem_wr_addr  <= AW'(r_wr_ptr);
          r_mem_wr_data  <= host_data;
          r_wr_ptr       <= r_wr_ptr + PW'(1);
          r_vertex_count <= 32'(r_wr_ptr) + 32'd1;
        end
      end

      r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + SW'(1) : '0;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TW            = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TIMEOUT_LIMIT = TIMEOUT_CYCLES - 2;

  logic [TW-1:0] r_run_cnt;
  logic          r_err_timeout;

  // Cycles since gpu_start; the limit sits two below TIMEOUT_CYCLES so that frame_done
  // (one DONE cycle plus its registered pulse) lands TIMEOUT_CYCLES after gpu_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_cnt <= '0;
    end else if (r_state == S_START) begin
      r_run_cnt <= TW'(1);
    end else if (r_state == S_RUN) begin
      r_run_cnt <= r_run_cnt + TW'(1);
    end
  end

  assign w_timeout = (r_state == S_RUN) && (r_run_cnt >= TW'(TIMEOUT_LIMIT));

  // Sticky watchdog flag, cleared by an accepted frame request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_timeout <= 1'b0;
    end else if (r_state == S_IDLE && w_req) begin
      r_err_timeout <= 1'b0;
    end else if (w_timeout && !w_fe_rise) begin
      r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign host_ready   = r_host_ready;
  assign mem_wr_en    = r_mem_wr_en;
  assign mem_wr_addr  = r_mem_wr_addr;
  assign mem_wr_data  = r_mem_wr_data;
  assign vertex_count = r_vertex_count;
  assign gpu_start    = r_gpu_start;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// Scoreboard bench for gpu_frame_sequencer: the driver pushes expected writes,
// start and done events; a negedge monitor pops and compares them.
module tb_gpu_frame_sequencer;

  localparam int unsigned M      = 11;
  localparam int unsigned N      = 7;
  localparam int unsigned W      = M + N;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned SETTLE = 16;
  localparam int unsigned TMO    = 100;

  logic                clk = 1'b0;
  logic                reset;
  logic                frame_req, frame_reload;
  logic                host_valid, host_ready, host_last;
  logic signed [W-1:0] host_data, mem_wr_data;
  logic                mem_wr_en;
  logic [AW-1:0]       mem_wr_addr;
  logic [31:0]         vertex_count;
  logic                gpu_start, gpu_frame_end;
  logic                busy, frame_done, err_overflow, err_timeout;

  gpu_frame_sequencer #(
    .M(M), .N(N), .VERTEX_MEM_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .frame_req(frame_req), .frame_reload(frame_reload),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .host_last(host_last), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .vertex_count(vertex_count), .gpu_start(gpu_start),
    .gpu_frame_end(gpu_frame_end), .busy(busy), .frame_done(frame_done),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; logic signed [W-1:0] data; int cnt; } wr_t;
  typedef struct { int vcnt; int gap; } st_t;
  typedef struct { int vcnt; bit started; bit ovf; bit tmo; } dn_t;

  wr_t q_wr[$];
  st_t q_st[$];
  dn_t q_dn[$];
  int  q_dn_cyc[$];

  // Reference model state: words currently held in GPU memory.
  int stored_cnt = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every DUT event against the scoreboard.
  wr_t mw;
  st_t ms;
  dn_t md;
  int  md_cyc;
  int  last_wr_cyc = 0;
  bit  seen_start  = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_wr_en) begin
        if (q_wr.size() == 0) fail_now("unexpected_mem_write");
        else begin
          mw = q_wr.pop_front();
          chk("wr_addr", mem_wr_addr, mw.addr);
          chk("wr_data", mem_wr_data, mw.data);
          chk("wr_vertex_count", vertex_count, mw.cnt);
        end
        last_wr_cyc = cyc;
      end
      if (gpu_start) begin
        if (q_st.size() == 0) fail_now("unexpected_gpu_start");
        else begin
          ms = q_st.pop_front();
          chk("start_vertex_count", vertex_count, ms.vcnt);
          if (ms.gap >= 0) chk("settle_gap", cyc - last_wr_cyc, ms.gap);
        end
        seen_start = 1'b1;
      end
      if (frame_done) begin
        if (q_dn.size() == 0 || q_dn_cyc.size() == 0) fail_now("unexpected_frame_done");
        else begin
          md     = q_dn.pop_front();
          md_cyc = q_dn_cyc.pop_front();
          chk("done_cycle", cyc, md_cyc);
          chk("done_vertex_count", vertex_count, md.vcnt);
          chk("done_started", seen_start, md.started);
          chk("done_err_overflow", err_overflow, md.ovf);
          chk("done_err_timeout", err_timeout, md.tmo);
          chk("done_busy", busy, 0);
        end
        seen_start = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while ((busy || frame_done) && g < 2000) begin tick(); g++; end
    if (busy || frame_done) fail_now("idle_wait_expired");
  endtask

  // Send one beat and wait (bounded) for the handshake.
  task automatic send_beat(input logic signed [W-1:0] d, input bit last, output bit acc);
    int g = 0;
    host_valid = 1'b1; host_data = d; host_last = last;
    acc = 1'b0;
    while (!acc && g < 50) begin
      @(negedge clk);
      acc = host_ready;
      tick();
      g++;
    end
    host_valid = 1'b0; host_last = 1'b0;
  endtask

  // One complete frame: predict, drive, and wait for frame_done.
  task automatic run_frame(input bit reload, input int n, input int gap_mode,
                           input bit level_high, input bit poke_done, input bit tmo_frame);
    logic signed [W-1:0] words[$];
    int exp_cnt, req_cyc, acc_cnt, g, gaps;
    bit ovf, acc;
    wait_idle();
    ovf     = reload && (n > int'(DEPTH));
    exp_cnt = reload ? ((n > int'(DEPTH)) ? int'(DEPTH) : n) : stored_cnt;
    if (reload) begin
      for (int i = 0; i < n; i++) begin
        words.push_back(W'($urandom));
        if (i < int'(DEPTH)) q_wr.push_back('{i, words[i], i + 1});
      end
    end
    if (exp_cnt > 0) q_st.push_back('{exp_cnt, (reload && !ovf) ? int'(SETTLE + 1) : -1});
    q_dn.push_back('{exp_cnt, exp_cnt > 0, ovf, tmo_frame});

    gpu_frame_end = level_high;
    frame_req = 1'b1; frame_reload = reload; req_cyc = cyc;
    tick();
    frame_req = 1'b0; frame_reload = 1'b0;
    if (exp_cnt == 0) q_dn_cyc.push_back(req_cyc + 2);

    acc_cnt = 0;
    if (reload) begin
      for (int i = 0; i < n; i++) begin
        if (gap_mode == 0) gaps = int'($urandom_range(0, 2));
        else if (gap_mode == 2 && i > 0) gaps = 2;
        else gaps = 0;
        repeat (gaps) tick();
        send_beat(words[i], i == n - 1, acc);
        if (!acc) begin fail_now("beat_not_accepted"); break; end
        acc_cnt++;
      end
      chk("beats_accepted", acc_cnt, n);
    end
    stored_cnt = exp_cnt;

    if (exp_cnt > 0) begin
      g = 0;
      while (!gpu_start && g < 200) begin tick(); g++; end
      if (!gpu_start) fail_now("gpu_start_missing");
      else if (tmo_frame) q_dn_cyc.push_back(cyc + int'(TMO));
      else begin
        if (level_high) begin
          repeat (6) tick();
          chk("busy_under_held_level", busy, 1);
        end
        gpu_frame_end = 1'b0;
        tick();
        repeat ($urandom_range(0, 4)) tick();
        gpu_frame_end = 1'b1;
        q_dn_cyc.push_back(cyc + 2);
      end
    end

    g = 0;
    while (!frame_done && g < int'(TMO) + 300) begin tick(); g++; end
    if (!frame_done) fail_now("frame_done_missing");
    else if (poke_done) begin
      frame_req = 1'b1; frame_reload = 1'b1;
      tick();
      frame_req = 1'b0; frame_reload = 1'b0;
      chk("req_in_done_cycle_ignored", busy, 0);
      tick();
      chk("req_in_done_cycle_still_idle", busy, 0);
    end
    gpu_frame_end = 1'b0;
  endtask

  initial begin
    bit acc;
    logic signed [W-1:0] d;
    reset = 1'b1; frame_req = 1'b0; frame_reload = 1'b0; host_valid = 1'b0;
    host_data = '0; host_last = 1'b0; gpu_frame_end = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_vertex_count", vertex_count, 0);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_gpu_start", gpu_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_overflow", err_overflow, 0);
    chk("rst_err_timeout", err_timeout, 0);
    reset = 1'b0;
    tick();

    // 9-word reload, back-to-back beats, then a request during the done pulse.
    run_frame(1'b1, 9, 1, 1'b0, 1'b1, 1'b0);
    // Reuse the stored buffer while gpu_frame_end is already high at START.
    run_frame(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    // Overflow: 20 beats into a 16-word memory.
    run_frame(1'b1, 20, 0, 1'b0, 1'b0, 1'b0);
    // host_valid 1,0,0,1 pattern; also clears the overflow flag.
    run_frame(1'b1, 7, 2, 1'b0, 1'b0, 1'b0);
    // Randomized frames.
    for (int k = 0; k < 6; k++) begin
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(1, 20)), 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
`ifdef FRAME_TIMEOUT_EN
    run_frame(1'b1, 3, 1, 1'b0, 1'b0, 1'b1);
`endif

    // Reset in the middle of a load: four writes land, the fifth is cut off.
    wait_idle();
    frame_req = 1'b1; frame_reload = 1'b1;
    tick();
    frame_req = 1'b0; frame_reload = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = W'($urandom);
      if (i < 4) q_wr.push_back('{i, d, i + 1});
      send_beat(d, 1'b0, acc);
      if (!acc) fail_now("abort_beat_not_accepted");
    end
    reset = 1'b1;
    #1;
    chk("midload_rst_busy", busy, 0);
    chk("midload_rst_mem_wr_en", mem_wr_en, 0);
    chk("midload_rst_vertex_count", vertex_count, 0);
    chk("midload_rst_host_ready", host_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    stored_cnt = 0;
    tick();
    run_frame(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    repeat (3) tick();
    chk("wr_queue_drained", q_wr.size(), 0);
    chk("start_queue_drained", q_st.size(), 0);
    chk("done_queue_drained", q_dn.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

endmodule
